// File: rtl/control_unit.sv
// Hardwired Moore control FSM for the single-bus datapath: fetch, decode and T0..T7 sequencing.
// Optional build macro CU_SINGLE_STEP_EN adds a 'step' input that gates each instruction start in T0.
module control_unit #(
    parameter int NREG = 16,
    parameter int OPW  = 5
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [31:0]     ir,
    input  logic            mem_rdy,
`ifdef CU_SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic            PCout,
    output logic            Zlowout,
    output logic            ZHighout,
    output logic            MDRout,
    output logic            Cout,
    output logic            MARin,
    output logic            PCin,
    output logic            MDRin,
    output logic            IRin,
    output logic            Yin,
    output logic            IncPC,
    output logic            HIin,
    output logic            LOin,
    output logic            ZHIin,
    output logic            ZLOin,
    output logic            Read,
    output logic            Write,
    output logic [OPW-1:0]  operation,
    output logic [NREG-1:0] enableReg,
    output logic [NREG-1:0] Rout,
    output logic            run,
    output logic            illegal
);

    localparam logic [3:0] S_RST  = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_T7   = 4'd8;
    localparam logic [3:0] S_HALT = 4'd9;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    logic [3:0] state;
    logic [3:0] next_state;

    logic [4:0] opcode;
    logic [3:0] ra_field;
    logic [3:0] rb_field;
    logic [3:0] rc_field;

    logic is_alu;
    logic is_muldiv;
    logic is_ld;
    logic is_st;
    logic is_nop;
    logic is_halt;
    logic is_illegal;
    logic t0_go;

    logic [NREG-1:0] sel_ra;
    logic [NREG-1:0] sel_rb;
    logic [NREG-1:0] sel_rc;

    logic unused_ir_low;

    assign opcode        = ir[31:27];
    assign ra_field      = ir[26:23];
    assign rb_field      = ir[22:19];
    assign rc_field      = ir[18:15];
    assign unused_ir_low = ^ir[14:0];

    assign is_alu     = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL};
    assign is_muldiv  = opcode inside {OP_MUL, OP_DIV};
    assign is_ld      = (opcode == OP_LD);
    assign is_st      = (opcode == OP_ST);
    assign is_nop     = (opcode == OP_NOP);
    assign is_halt    = (opcode == OP_HALT);
    assign is_illegal = !(is_alu || is_muldiv || is_ld || is_st || is_nop || is_halt);

`ifdef CU_SINGLE_STEP_EN
    assign t0_go = step;
`else
    assign t0_go = 1'b1;
`endif

    // Field values that do not name an existing register select nothing.
    function automatic logic [NREG-1:0] reg_sel(input logic [3:0] field);
        logic [NREG-1:0] sel;
        sel = '0;
        for (int i = 0; i < NREG; i++) begin
            sel[i] = ({28'd0, field} == i[31:0]);
        end
        return sel;
    endfunction

    assign sel_ra = reg_sel(ra_field);
    assign sel_rb = reg_sel(rb_field);
    assign sel_rc = reg_sel(rc_field);

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_RST;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = S_RST;
        case (state)
            S_RST:  next_state = S_T0;
            S_T0:   next_state = t0_go ? S_T1 : S_T0;
            S_T1:   next_state = mem_rdy ? S_T2 : S_T1;
            S_T2:   next_state = S_T3;
            S_T3: begin
                if (is_halt) begin
                    next_state = S_HALT;
                end else if (is_alu || is_muldiv || is_ld || is_st) begin
                    next_state = S_T4;
                end else begin
                    next_state = S_T0;
                end
            end
            S_T4:   next_state = S_T5;
            S_T5:   next_state = is_alu ? S_T0 : S_T6;
            S_T6: begin
                if (is_ld) begin
                    next_state = mem_rdy ? S_T7 : S_T6;
                end else if (is_st) begin
                    next_state = S_T7;
                end else begin
                    next_state = S_T0;
                end
            end
            S_T7: begin
                if (is_st) begin
                    next_state = mem_rdy ? S_T0 : S_T7;
                end else begin
                    next_state = S_T0;
                end
            end
            S_HALT: next_state = S_HALT;
            default: next_state = S_RST;
        endcase
    end

    // Moore outputs; only the step gate in T0 looks past state and ir.
    always_comb begin
        PCout     = 1'b0;
        Zlowout   = 1'b0;
        ZHighout  = 1'b0;
        MDRout    = 1'b0;
        Cout      = 1'b0;
        MARin     = 1'b0;
        PCin      = 1'b0;
        MDRin     = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        IncPC     = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        ZHIin     = 1'b0;
        ZLOin     = 1'b0;
        Read      = 1'b0;
        Write     = 1'b0;
        operation = '0;
        enableReg = '0;
        Rout      = '0;
        illegal   = 1'b0;
        run       = (state != S_HALT);

        case (state)
            S_T0: begin
                if (t0_go) begin
                    PCout = 1'b1;
                    MARin = 1'b1;
                    IncPC = 1'b1;
                    ZLOin = 1'b1;
                end
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (is_alu || is_ld || is_st) begin
                    Rout = sel_rb;
                    Yin  = 1'b1;
                end else if (is_muldiv) begin
                    Rout = sel_ra;
                    Yin  = 1'b1;
                end else if (is_illegal) begin
                    illegal = 1'b1;
                end
            end
            S_T4: begin
                if (is_alu) begin
                    Rout      = sel_rc;
                    ZLOin     = 1'b1;
                    operation = OPW'(opcode);
                end else if (is_muldiv) begin
                    Rout      = sel_rb;
                    ZLOin     = 1'b1;
                    ZHIin     = 1'b1;
                    operation = OPW'(opcode);
                end else if (is_ld || is_st) begin
                    // Effective address C + Rb is formed with the ALU add.
                    Cout      = 1'b1;
                    ZLOin     = 1'b1;
                    operation = OPW'(OP_ADD);
                end
            end
            S_T5: begin
                if (is_alu) begin
                    Zlowout   = 1'b1;
                    enableReg = sel_ra;
                end else if (is_muldiv) begin
                    Zlowout = 1'b1;
                    LOin    = 1'b1;
                end else if (is_ld || is_st) begin
                    Zlowout = 1'b1;
                    MARin   = 1'b1;
                end
            end
            S_T6: begin
                if (is_muldiv) begin
                    ZHighout = 1'b1;
                    HIin     = 1'b1;
                end else if (is_ld) begin
                    Read  = 1'b1;
                    MDRin = 1'b1;
                end else if (is_st) begin
                    Rout  = sel_ra;
                    MDRin = 1'b1;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    MDRout    = 1'b1;
                    enableReg = sel_ra;
                end else if (is_st) begin
                    Write = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected per-cycle strobe vectors are queued as stimulus is
// driven and compared on the falling edge against the DUT outputs.
module tb_control_unit;

    localparam logic [18:0] PCOUT    = 19'h40000;
    localparam logic [18:0] ZLOWOUT  = 19'h20000;
    localparam logic [18:0] ZHIGHOUT = 19'h10000;
    localparam logic [18:0] MDROUT   = 19'h08000;
    localparam logic [18:0] COUT     = 19'h04000;
    localparam logic [18:0] MARIN    = 19'h02000;
    localparam logic [18:0] PCIN     = 19'h01000;
    localparam logic [18:0] MDRIN    = 19'h00800;
    localparam logic [18:0] IRIN     = 19'h00400;
    localparam logic [18:0] YIN      = 19'h00200;
    localparam logic [18:0] INCPC    = 19'h00100;
    localparam logic [18:0] HIIN     = 19'h00080;
    localparam logic [18:0] LOIN     = 19'h00040;
    localparam logic [18:0] ZHIIN    = 19'h00020;
    localparam logic [18:0] ZLOIN    = 19'h00010;
    localparam logic [18:0] READ     = 19'h00008;
    localparam logic [18:0] WRITE    = 19'h00004;
    localparam logic [18:0] RUN      = 19'h00002;
    localparam logic [18:0] ILL      = 19'h00001;

    localparam logic [18:0] T0S = PCOUT | MARIN | INCPC | ZLOIN | RUN;
    localparam logic [18:0] T1S = ZLOWOUT | PCIN | READ | MDRIN | RUN;
    localparam logic [18:0] T2S = MDROUT | IRIN | RUN;

    logic        clk;
    logic        clr;
    logic [31:0] ir;
    logic        mem_rdy;
    logic        PCout, Zlowout, ZHighout, MDRout, Cout;
    logic        MARin, PCin, MDRin, IRin, Yin, IncPC;
    logic        HIin, LOin, ZHIin, ZLOin;
    logic        Read, Write, run, illegal;
    logic [4:0]  operation;
    logic [15:0] enableReg;
    logic [15:0] Rout;

    string       tag_q[$];
    logic [55:0] exp_q[$];
    int          n_compared;
    int          n_mismatched;

    control_unit #(.NREG(16), .OPW(5)) dut (
        .clk(clk),
        .clr(clr),
        .ir(ir),
        .mem_rdy(mem_rdy),
`ifdef CU_SINGLE_STEP_EN
        .step(1'b1),
`endif
        .PCout(PCout),
        .Zlowout(Zlowout),
        .ZHighout(ZHighout),
        .MDRout(MDRout),
        .Cout(Cout),
        .MARin(MARin),
        .PCin(PCin),
        .MDRin(MDRin),
        .IRin(IRin),
        .Yin(Yin),
        .IncPC(IncPC),
        .HIin(HIin),
        .LOin(LOin),
        .ZHIin(ZHIin),
        .ZLOin(ZLOin),
        .Read(Read),
        .Write(Write),
        .operation(operation),
        .enableReg(enableReg),
        .Rout(Rout),
        .run(run),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [55:0] ex(input logic [18:0] s, input logic [4:0] op,
                                       input logic [15:0] en, input logic [15:0] ro);
        return {s, op, en, ro};
    endfunction

    task automatic checkOutput(input string tag, input logic [55:0] observed, input logic [55:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got strobes=%05h op=%02h en=%04h rout=%04h, expected strobes=%05h op=%02h en=%04h rout=%04h",
                     tag, observed[55:37], observed[36:32], observed[31:16], observed[15:0],
                     expected[55:37], expected[36:32], expected[31:16], expected[15:0]);
        end
    endtask

    // Inputs for this cycle plus the outputs the current state must show; advances one clock.
    task automatic applyStimulus(input string tag, input logic c, input logic rdy, input logic [55:0] e);
        clr     = c;
        mem_rdy = rdy;
        tag_q.push_back(tag);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_fetch(input string name, input logic [31:0] instr);
        ir = instr;
        applyStimulus({name, "_t0"}, 1'b0, 1'b1, ex(T0S, 5'b0, 16'h0, 16'h0));
        applyStimulus({name, "_t1"}, 1'b0, 1'b1, ex(T1S, 5'b0, 16'h0, 16'h0));
        applyStimulus({name, "_t2"}, 1'b0, 1'b1, ex(T2S, 5'b0, 16'h0, 16'h0));
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            checkOutput(tag_q.pop_front(),
                        {PCout, Zlowout, ZHighout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin,
                         IncPC, HIin, LOin, ZHIin, ZLOin, Read, Write, run, illegal,
                         operation, enableReg, Rout},
                        exp_q.pop_front());
        end
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        clr          = 1'b1;
        mem_rdy      = 1'b1;
        ir           = 32'h0;
        @(posedge clk);
        #1;

        ir = 32'h28918000;
        applyStimulus("rst", 1'b0, 1'b1, ex(RUN, 5'b0, 16'h0, 16'h0));
        run_fetch("and", 32'h28918000);
        applyStimulus("and_t3", 1'b0, 1'b1, ex(YIN | RUN, 5'b0, 16'h0, 16'h0004));
        applyStimulus("and_t4", 1'b0, 1'b1, ex(ZLOIN | RUN, 5'b00101, 16'h0, 16'h0008));
        applyStimulus("and_t5", 1'b0, 1'b1, ex(ZLOWOUT | RUN, 5'b0, 16'h0002, 16'h0));

        ir = 32'hD0000000;
        applyStimulus("wfetch_t0", 1'b0, 1'b1, ex(T0S, 5'b0, 16'h0, 16'h0));
        for (int i = 0; i < 3; i++) begin
            applyStimulus($sformatf("wfetch_t1_wait%0d", i), 1'b0, 1'b0, ex(T1S, 5'b0, 16'h0, 16'h0));
        end
        applyStimulus("wfetch_t1_go", 1'b0, 1'b1, ex(T1S, 5'b0, 16'h0, 16'h0));
        applyStimulus("wfetch_t2", 1'b0, 1'b1, ex(T2S, 5'b0, 16'h0, 16'h0));
        applyStimulus("nop_t3", 1'b0, 1'b1, ex(RUN, 5'b0, 16'h0, 16'h0));

        run_fetch("ld", 32'h00900014);
        applyStimulus("ld_t3", 1'b0, 1'b1, ex(YIN | RUN, 5'b0, 16'h0, 16'h0004));
        applyStimulus("ld_t4", 1'b0, 1'b1, ex(COUT | ZLOIN | RUN, 5'b00011, 16'h0, 16'h0));
        applyStimulus("ld_t5", 1'b0, 1'b1, ex(ZLOWOUT | MARIN | RUN, 5'b0, 16'h0, 16'h0));
        applyStimulus("ld_t6_wait0", 1'b0, 1'b0, ex(READ | MDRIN | RUN, 5'b0, 16'h0, 16'h0));
        applyStimulus("ld_t6_wait1", 1'b0, 1'b0, ex(READ | MDRIN | RUN, 5'b0, 16'h0, 16'h0));
        applyStimulus("ld_t6_go", 1'b0, 1'b1, ex(READ | MDRIN | RUN, 5'b0, 16'h0, 16'h0));
        applyStimulus("ld_t7", 1'b0, 1'b1, ex(MDROUT | RUN, 5'b0, 16'h0002, 16'h0));

        run_fetch("mul", 32'h79A00000);
        applyStimulus("mul_t3", 1'b0, 1'b1, ex(YIN | RUN, 5'b0, 16'h0, 16'h0008));
        applyStimulus("mul_t4", 1'b0, 1'b1, ex(ZLOIN | ZHIIN | RUN, 5'b01111, 16'h0, 16'h0010));
        applyStimulus("mul_t5", 1'b0, 1'b1, ex(ZLOWOUT | LOIN | RUN, 5'b0, 16'h0, 16'h0));
        applyStimulus("mul_t6", 1'b0, 1'b1, ex(ZHIGHOUT | HIIN | RUN, 5'b0, 16'h0, 16'h0));

        for (int k = 0; k < 2; k++) begin
            run_fetch($sformatf("st%0d", k), 32'h10900014);
            applyStimulus("st_t3", 1'b0, 1'b1, ex(YIN | RUN, 5'b0, 16'h0, 16'h0004));
            applyStimulus("st_t4", 1'b0, 1'b1, ex(COUT | ZLOIN | RUN, 5'b00011, 16'h0, 16'h0));
            applyStimulus("st_t5", 1'b0, 1'b1, ex(ZLOWOUT | MARIN | RUN, 5'b0, 16'h0, 16'h0));
            applyStimulus("st_t6", 1'b0, 1'b1, ex(MDRIN | RUN, 5'b0, 16'h0, 16'h0002));
            applyStimulus("st_t7_wait", 1'b0, 1'b0, ex(WRITE | RUN, 5'b0, 16'h0, 16'h0));
            if (k == 0) begin
                applyStimulus("st_t7_go", 1'b0, 1'b1, ex(WRITE | RUN, 5'b0, 16'h0, 16'h0));
            end else begin
                applyStimulus("st_t7_clr", 1'b1, 1'b0, ex(WRITE | RUN, 5'b0, 16'h0, 16'h0));
                applyStimulus("st_abort_rst", 1'b0, 1'b0, ex(RUN, 5'b0, 16'h0, 16'h0));
            end
        end

        run_fetch("ill", 32'hF8000000);
        applyStimulus("ill_t3", 1'b0, 1'b1, ex(ILL | RUN, 5'b0, 16'h0, 16'h0));

        run_fetch("halt", 32'hD8000000);
        applyStimulus("halt_t3", 1'b0, 1'b1, ex(RUN, 5'b0, 16'h0, 16'h0));
        for (int i = 0; i < 20; i++) begin
            applyStimulus($sformatf("halt_hold%0d", i), 1'b0, 1'b1, ex(19'h0, 5'b0, 16'h0, 16'h0));
        end
        applyStimulus("halt_clr", 1'b1, 1'b1, ex(19'h0, 5'b0, 16'h0, 16'h0));
        applyStimulus("halt_rst", 1'b0, 1'b1, ex(RUN, 5'b0, 16'h0, 16'h0));
        applyStimulus("resume_t0", 1'b0, 1'b1, ex(T0S, 5'b0, 16'h0, 16'h0));

        checkOutput("scoreboard_drain", 56'(exp_q.size()), 56'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
